matvec_stream: RTL and testbench

Parametrised streaming signed matrix-vector multiplier computing y = W·x for a K×K matrix. It is the successor of the fixed 8×8 multiplier, with configurable K, input and output widths, plus an end-of-vector marker. Input words and results each use a valid/ready handshake. A stored matrix is reused across vectors until a new one is streamed in.

---
 rtl/matvec_pkg.sv | 40 ++++
 rtl/matvec_stream_mac.sv | 55 +++++
 rtl/matvec_stream.sv | 178 +++++++++++++++++
 tb/tb_matvec_stream.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matvec_pkg
// Description : Shared types and helpers for the streaming matrix-vector
//               multiplier: FSM state encoding, accumulator width and the
//               signed saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package matvec_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Full-precision accumulator width: the product of two IW-bit signed words
    // plus enough headroom for K terms.
    function automatic int accw(input int iw, input int k);
        return 2 * iw + $clog2(k);
    endfunction

    // Clamp a signed value into the range of an ow-bit signed word.
    // Works on a 64-bit carrier, so ow is assumed to be below 64.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int                 ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_stream_mac.sv
`default_nettype none
// ============================================================================
// Module      : matvec_mac
// Description : Registered signed multiplier feeding a full-precision
//               accumulator.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the accumulator (asserted with the first product issue)
//   enable     : a*b is captured into the product register this cycle
//   flush      : drain cycle; sum is final, accumulator returns to zero
//   a, b       : signed operands
//   sum        : accumulator plus the in-flight product (final on flush)
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_mac #(
    parameter int IW   = 14,
    parameter int ACCW = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   flush,
    input  logic signed [IW-1:0]   a,
    input  logic signed [IW-1:0]   b,
    output logic signed [ACCW-1:0] sum
);

    logic signed [2*IW-1:0] r_prod;
    logic                   r_prod_vld;
    logic signed [ACCW-1:0] r_acc;
    logic signed [ACCW-1:0] w_prod_ext;

    assign w_prod_ext = r_prod_vld ? ACCW'(r_prod) : {ACCW{1'b0}};
    // The last product is still in the register on the flush cycle, so the
    // result is taken from the adder rather than the accumulator itself.
    assign sum        = r_acc + w_prod_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= enable;
            if (enable)
                r_prod <= (2*IW)'(a) * (2*IW)'(b);
            if (clear || flush)
                r_acc <= '0;
            else
                r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matvec_stream.sv
`default_nettype none
// ============================================================================
// Module      : matvec_stream
// Description : Streaming signed K x K matrix-vector multiplier, y = W * x.
//               A transaction whose first word has new_matrix=1 carries K*K
//               matrix words (row-major) followed by K vector words; otherwise
//               it carries K vector words and the stored matrix is reused.
//               Each row takes K+1 cycles through matvec_mac and is presented
//               on a valid/ready output with output_last on y[K-1].
//   clk, reset     : clock, asynchronous active-high reset
//   input_*        : word input handshake (input_data, new_matrix)
//   output_*       : result handshake (output_data, output_last)
// Build option : MATVEC_SAT_EN - clamp results to OW bits instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_stream
    import matvec_pkg::*;
#(
    parameter int K  = 8,
    parameter int IW = 14,
    parameter int OW = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic signed [IW-1:0] input_data,
    input  logic                 new_matrix,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic signed [OW-1:0] output_data,
    output logic                 output_last
);

    localparam int ACCW = accw(IW, K);
    localparam int KW   = $clog2(K);
    localparam logic [KW-1:0] KMAX = KW'(K - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [IW-1:0] r_w [K][K];
    logic signed [IW-1:0] r_x [K];

    // The matrix write counter is kept as a row/column pair (wcnt = row*K+col).
    logic [KW-1:0] r_wrow, r_wcol, r_xcnt, r_row, r_col;
    logic          r_drain;    // last product issued, next MAC cycle drains
    logic          r_active;   // a transaction has accepted its first word
    logic          r_load_w;   // active transaction is still in its W phase

    logic w_accept, w_to_w, w_w_last, w_x_last;
    logic w_issue, w_flush, w_out_hs;
    logic signed [ACCW-1:0] w_sum;
    logic signed [OW-1:0]   w_result;

    // new_matrix only matters on the first word of a transaction.
    assign w_to_w   = r_active ? r_load_w : new_matrix;
    assign w_w_last = (r_wrow == KMAX) && (r_wcol == KMAX);
    assign w_x_last = (r_xcnt == KMAX);

    assign input_ready = (r_state == S_LOAD) && !reset;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        w_out_hs    = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_accept = input_valid;
                if (input_valid && !w_to_w && w_x_last)
                    w_state_nxt = S_MAC;
            end
            S_MAC: begin
                if (r_drain) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_OUT;
                end else begin
                    w_issue = 1'b1;
                end
            end
            S_OUT: begin
                if (output_ready) begin
                    w_out_hs    = 1'b1;
                    w_state_nxt = (r_row == KMAX) ? S_LOAD : S_MAC;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_LOAD;
        else
            r_state <= w_state_nxt;
    end

    matvec_mac #(
        .IW   (IW),
        .ACCW (ACCW)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_issue && (r_col == '0)),
        .enable (w_issue),
        .flush  (w_flush),
        .a      (r_w[r_row][r_col]),
        .b      (r_x[r_col]),
        .sum    (w_sum)
    );

`ifdef MATVEC_SAT_EN
    assign w_result = OW'(sat(64'(w_sum), OW));
`else
    assign w_result = OW'(w_sum);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                r_x[i] <= '0;
                for (int j = 0; j < K; j++)
                    r_w[i][j] <= '0;
            end
            r_wrow       <= '0;
            r_wcol       <= '0;
            r_xcnt       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_drain      <= 1'b0;
            r_active     <= 1'b0;
            r_load_w     <= 1'b0;
            output_valid <= 1'b0;
            output_data  <= '0;
            output_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_active <= w_to_w || !w_x_last;
                if (w_to_w) begin
                    r_w[r_wrow][r_wcol] <= input_data;
                    r_load_w            <= !w_w_last;
                    if (r_wcol == KMAX) begin
                        r_wcol <= '0;
                        r_wrow <= (r_wrow == KMAX) ? '0 : r_wrow + 1'b1;
                    end else begin
                        r_wcol <= r_wcol + 1'b1;
                    end
                end else begin
                    r_x[r_xcnt] <= input_data;
                    r_load_w    <= 1'b0;
                    r_xcnt      <= w_x_last ? '0 : r_xcnt + 1'b1;
                end
            end

            if (w_issue) begin
                r_col   <= (r_col == KMAX) ? '0 : r_col + 1'b1;
                r_drain <= (r_col == KMAX);
            end

            if (w_flush) begin
                r_drain      <= 1'b0;
                output_valid <= 1'b1;
                output_data  <= w_result;
                output_last  <= (r_row == KMAX);
            end

            if (w_out_hs) begin
                output_valid <= 1'b0;
                output_last  <= 1'b0;
                r_row        <= (r_row == KMAX) ? '0 : r_row + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matvec_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_matvec_stream
// Description : Self-checking bench for matvec_stream (K=8, IW=14, OW=28).
//               Table of vectors with hand-computed results, plus sequences
//               for latency, backpressure and reset in mid-load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matvec_stream;

    localparam int K  = 8;
    localparam int IW = 14;
    localparam int OW = 28;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 input_valid;
    logic                 input_ready;
    logic signed [IW-1:0] input_data;
    logic                 new_matrix;
    logic                 output_valid;
    logic                 output_ready;
    logic signed [OW-1:0] output_data;
    logic                 output_last;

    matvec_stream #(.K(K), .IW(IW), .OW(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .new_matrix   (new_matrix),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_last  (output_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // wmode: 0 none (reuse), 1 identity, 2 all wval, 3 lower-triangular ones
    typedef struct {
        bit nm;
        int wmode;
        int wval;
        int x    [K];
        int y    [K];
        int ysat [K];
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic int wgen(input int mode, input int val, input int r, input int c);
        case (mode)
            1:       return (r == c) ? 1 : 0;
            2:       return val;
            3:       return (c <= r) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic send_word(input int d, input bit nm, input bit gaps);
        int guard;
        if (gaps && $urandom_range(0, 2) == 0) begin
            @(negedge clk);
            input_valid = 1'b0;
            input_data  = 'x;
            new_matrix  = 1'bx;
        end
        @(negedge clk);
        input_valid = 1'b1;
        input_data  = IW'(d);
        new_matrix  = nm;
        guard = 0;
        while (!input_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300)
            timeout("send_word");
        @(posedge clk);
        #1;
    endtask

    // new_matrix is driven inverted on every word after the first to show
    // that only the first word's flag matters.
    task automatic send_vector(input int idx, input bit gaps);
        bit first;
        first = 1'b1;
        if (tbl[idx].nm) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) begin
                    send_word(wgen(tbl[idx].wmode, tbl[idx].wval, r, c),
                              first ? 1'b1 : 1'b0, gaps);
                    first = 1'b0;
                end
        end
        for (int c = 0; c < K; c++) begin
            send_word(tbl[idx].x[c], first ? tbl[idx].nm : !tbl[idx].nm, gaps);
            first = 1'b0;
        end
        input_valid = 1'b0;
        input_data  = 'x;
        new_matrix  = 1'bx;
    endtask

    task automatic collect(input int idx, input int first_row, input int last_row);
        int guard;
        int e;
        for (int r = first_row; r <= last_row; r++) begin
            guard = 0;
            while (!output_valid && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) begin
                timeout($sformatf("v%0d_y%0d", idx, r));
                return;
            end
`ifdef MATVEC_SAT_EN
            e = tbl[idx].ysat[r];
`else
            e = tbl[idx].y[r];
`endif
            check($sformatf("v%0d_y%0d", idx, r), output_data, e);
            check($sformatf("v%0d_last%0d", idx, r), output_last, (r == K - 1) ? 1 : 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;

        // ---------------- vector table ----------------
        tbl[0] = '{nm: 1'b1, wmode: 1, wval: 0, default: '{default: 0}};
        tbl[0].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[0].y = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[1] = '{nm: 1'b0, wmode: 0, wval: 0, default: '{default: 0}};
        tbl[1].x = '{2, 2, 2, 2, 2, 2, 2, 2};
        tbl[1].y = '{2, 2, 2, 2, 2, 2, 2, 2};
        tbl[2] = '{nm: 1'b0, wmode: 0, wval: 0, default: '{default: 0}};
        tbl[2].x = '{-3, 5, 0, 7, -8, 1, 2, -1};
        tbl[2].y = '{-3, 5, 0, 7, -8, 1, 2, -1};
        tbl[3] = '{nm: 1'b1, wmode: 3, wval: 0, default: '{default: 0}};
        tbl[3].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[3].y = '{1, 3, 6, 10, 15, 21, 28, 36};
        tbl[4] = '{nm: 1'b0, wmode: 0, wval: 0, default: '{default: 0}};
        tbl[4].x = '{-1, -1, -1, -1, -1, -1, -1, -1};
        tbl[4].y = '{-1, -2, -3, -4, -5, -6, -7, -8};
        tbl[5] = '{nm: 1'b1, wmode: 2, wval: -2, default: '{default: 0}};
        tbl[5].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[5].y = '{-72, -72, -72, -72, -72, -72, -72, -72};
        tbl[6] = '{nm: 1'b1, wmode: 2, wval: 8191, default: '{default: 0}};
        tbl[6].x = '{default: 8191};
        tbl[6].y = '{default: -131064};
        tbl[7] = '{nm: 1'b1, wmode: 2, wval: -8192, default: '{default: 0}};
        tbl[7].x = '{default: -8192};
        tbl[7].y = '{default: 0};
        tbl[8] = '{nm: 1'b0, wmode: 0, wval: 0, default: '{default: 0}};
        tbl[8].x = '{default: 8191};
        tbl[8].y = '{default: 65536};
        tbl[9] = '{nm: 1'b0, wmode: 0, wval: 0, default: '{default: 0}};
        tbl[9].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[9].y = '{default: 0};
        for (int i = 0; i < 10; i++)
            tbl[i].ysat = tbl[i].y;
        tbl[6].ysat = '{default: 134217727};
        tbl[7].ysat = '{default: 134217727};
        tbl[8].ysat = '{default: -134217728};

        // ---------------- reset state ----------------
        reset        = 1'b1;
        input_valid  = 1'b0;
        input_data   = 'x;
        new_matrix   = 1'b0;
        output_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", input_ready, 0);
        check("rst_valid", output_valid, 0);
        check("rst_data", output_data, 0);
        check("rst_last", output_last, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", input_ready, 1);
        check("valid_after_rst", output_valid, 0);

        // ---------------- load identity, latency ----------------
        send_vector(0, 1'b0);
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (!output_valid && cnt < 40);
        check("first_latency", cnt, K + 1);
        collect(0, 0, K - 1);
        @(negedge clk);
        check("ready_after_last", input_ready, 1);

        // ---------------- reuse: exactly K words ----------------
        send_vector(1, 1'b0);
        check("ready_drop_after_K", input_ready, 0);
        collect(1, 0, K - 1);

        // ---------------- table sweep ----------------
        for (int i = 2; i <= 8; i++) begin
            send_vector(i, i[0]);
            collect(i, 0, K - 1);
        end

        // ---------------- backpressure at y[3] ----------------
        send_vector(3, 1'b0);
        collect(3, 0, 2);
        output_ready = 1'b0;
        guard = 0;
        while (!output_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300)
            timeout("bp_wait");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid", output_valid, 1);
            check("bp_data", output_data, 10);
            check("bp_input_ready", input_ready, 0);
        end
        output_ready = 1'b1;
        collect(3, 3, K - 1);

        // ---------------- reset after 30 W words ----------------
        for (int i = 0; i < 30; i++)
            send_word(5, (i == 0) ? 1'b1 : 1'b0, 1'b0);
        input_valid = 1'b0;
        input_data  = 'x;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", output_valid, 0);
        check("midrst_data", output_data, 0);
        check("midrst_last", output_last, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", input_ready, 1);
        send_vector(9, 1'b0);
        collect(9, 0, K - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
